// File: rtl/cache_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Purpose  : Shared types, geometry constants and address helpers for the
//            8-row, 4-way set-associative write-back cache controller.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

  localparam int CACHE_NUM_ROW = 8;
  localparam int CACHE_NUM_SET = 4;
  localparam int ADDR_W        = 16;
  localparam int WORD_W        = 16;
  localparam int BLOCK_W       = 32;
  localparam int TAG_W         = 11;
  localparam int IDX_W         = 3;
  localparam int OFF_W         = 2;
  localparam int WAY_W         = 2;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } INSTR_TYPE;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    WB_REQ   = 3'd2,
    WB_DRAIN = 3'd3,
    FILL_REQ = 3'd4,
    RESPOND  = 3'd5
  } ctrl_state_t;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  // Block-aligned memory address for a given tag and row
  function automatic logic [ADDR_W-1:0] blk_addr(input logic [TAG_W-1:0] tag,
                                                 input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

  // Select the upper or lower halfword of a block
  function automatic logic [WORD_W-1:0] half_of(input logic [BLOCK_W-1:0] blk,
                                                input logic hi);
    return hi ? blk[BLOCK_W-1:WORD_W] : blk[WORD_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_ctrl_fsm_lru.sv
`default_nettype none
// ============================================================================
// Module   : cache_lru
// Purpose  : Per-row age vectors (2 bits per way) for true-LRU replacement.
//            Age 0 is most recent, age 3 is the replacement candidate.
// Revision : 1.0 - initial release
// ============================================================================
module cache_lru
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic [WAY_W-1:0] upd_way_i,
  output logic [WAY_W-1:0] victim_way_o
);

  logic [WAY_W-1:0] age_q [CACHE_NUM_ROW][CACHE_NUM_SET];
  logic [WAY_W-1:0] old_age;

  assign old_age = age_q[upd_idx_i][upd_way_i];

  // Touch a way: it becomes youngest, ways younger than it age by one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < CACHE_NUM_ROW; r++) begin
        for (int w = 0; w < CACHE_NUM_SET; w++) begin
          age_q[r][w] <= WAY_W'(w);
        end
      end
    end else if (upd_en_i) begin
      for (int w = 0; w < CACHE_NUM_SET; w++) begin
        if (WAY_W'(w) == upd_way_i) begin
          age_q[upd_idx_i][w] <= '0;
        end else if (age_q[upd_idx_i][w] < old_age) begin
          age_q[upd_idx_i][w] <= age_q[upd_idx_i][w] + WAY_W'(1);
        end
      end
    end
  end

  // Oldest way of the looked-up row
  always_comb begin
    victim_way_o = '0;
    for (int w = 0; w < CACHE_NUM_SET; w++) begin
      if (age_q[rd_idx_i][w] == '1) begin
        victim_way_o = WAY_W'(w);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl_fsm
// Purpose  : Write-back, write-allocate cache controller. Handles one CPU
//            halfword request at a time: hit, dirty-victim writeback and
//            block refill over the RAM load/store handshake.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl_fsm
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  INSTR_TYPE           cpu_instr_type,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [WORD_W-1:0]   cpu_wdata,
  output logic [WORD_W-1:0]   cpu_rdata,
  output logic                cpu_ready,
  output logic                cpu_err,
  output logic [ADDR_W-1:0]   address_to_mem,
  output logic [BLOCK_W-1:0]  data_to_mem,
  output logic                mem_store_req,
  input  logic                mem_store_completed,
  output logic                mem_load_req,
  input  logic                mem_load_req_rdy,
  input  logic [BLOCK_W-1:0]  data_f_mem
);

  // Request context; bit 0 of the address is only needed for the alignment check
  ctrl_state_t          state_q;
  logic [ADDR_W-1:1]    addr_q;
  INSTR_TYPE            type_q;
  logic [WORD_W-1:0]    wdata_q;
  logic [WAY_W-1:0]     way_q;
  logic                 fill_first_q;

  // Cache arrays
  logic [CACHE_NUM_SET-1:0] valid_q [CACHE_NUM_ROW];
  logic [CACHE_NUM_SET-1:0] dirty_q [CACHE_NUM_ROW];
  logic [TAG_W-1:0]         tag_q   [CACHE_NUM_ROW][CACHE_NUM_SET];
  logic [BLOCK_W-1:0]       data_q  [CACHE_NUM_ROW][CACHE_NUM_SET];

  // Registered outputs
  logic [WORD_W-1:0]    cpu_rdata_q;
  logic                 cpu_ready_q;
  logic                 cpu_err_q;
  logic [ADDR_W-1:0]    addr_mem_q;
  logic [BLOCK_W-1:0]   data_mem_q;
  logic                 store_req_q;
  logic                 load_req_q;

  logic [ADDR_W-1:0]    addr_full;
  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic                 req_hi;
  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic                 any_inv;
  logic [WAY_W-1:0]     inv_way;
  logic [WAY_W-1:0]     lru_victim;
  logic [WAY_W-1:0]     victim_way;
  logic                 victim_dirty;
  logic                 fill_take;
  logic                 merge_we;
  logic                 lru_upd;

  assign addr_full = {addr_q, 1'b0};
  assign req_tag   = tag_of(addr_full);
  assign req_idx   = idx_of(addr_full);
  assign req_hi    = addr_q[1];

  // Refill data is accepted only from a rdy seen after the first request cycle
  assign fill_take = (state_q == FILL_REQ) && !fill_first_q && mem_load_req_rdy;
  assign merge_we  = (state_q == RESPOND) && !cpu_err_q && (type_q == WRITE);
  assign lru_upd   = (state_q == RESPOND) && !cpu_err_q;

  cache_lru u_lru (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_idx_i     (req_idx),
    .upd_en_i     (lru_upd),
    .upd_idx_i    (req_idx),
    .upd_way_i    (way_q),
    .victim_way_o (lru_victim)
  );

  // Tag compare and victim choice: lowest invalid way first, else the LRU way
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = CACHE_NUM_SET - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx][w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    victim_way   = any_inv ? inv_way : lru_victim;
    victim_dirty = valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way];
  end

  // Tag and data storage have no reset; valid bits guard their contents
  always_ff @(posedge clk) begin
    if (fill_take) begin
      tag_q[req_idx][way_q]  <= req_tag;
      data_q[req_idx][way_q] <= data_f_mem;
    end else if (merge_we) begin
      if (req_hi) begin
        data_q[req_idx][way_q][BLOCK_W-1:WORD_W] <= wdata_q;
      end else begin
        data_q[req_idx][way_q][WORD_W-1:0] <= wdata_q;
      end
    end
  end

  // Controller state machine with registered outputs and valid/dirty tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      type_q       <= READ;
      wdata_q      <= '0;
      way_q        <= '0;
      fill_first_q <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_ready_q  <= 1'b0;
      cpu_err_q    <= 1'b0;
      addr_mem_q   <= '0;
      data_mem_q   <= '0;
      store_req_q  <= 1'b0;
      load_req_q   <= 1'b0;
      for (int r = 0; r < CACHE_NUM_ROW; r++) begin
        valid_q[r] <= '0;
        dirty_q[r] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr[ADDR_W-1:1];
            type_q  <= cpu_instr_type;
            wdata_q <= cpu_wdata;
            if (cpu_addr[0]) begin
              cpu_ready_q <= 1'b1;
              cpu_err_q   <= 1'b1;
              state_q     <= RESPOND;
            end else begin
              state_q <= LOOKUP;
            end
          end
        end

        LOOKUP: begin
          if (hit) begin
            way_q       <= hit_way;
            cpu_ready_q <= 1'b1;
            if (type_q == READ) begin
              cpu_rdata_q <= half_of(data_q[req_idx][hit_way], req_hi);
            end
            state_q <= RESPOND;
          end else begin
            way_q <= victim_way;
            if (victim_dirty) begin
              store_req_q <= 1'b1;
              addr_mem_q  <= blk_addr(tag_q[req_idx][victim_way], req_idx);
              data_mem_q  <= data_q[req_idx][victim_way];
              state_q     <= WB_REQ;
            end else begin
              load_req_q   <= 1'b1;
              addr_mem_q   <= blk_addr(req_tag, req_idx);
              fill_first_q <= 1'b1;
              state_q      <= FILL_REQ;
            end
          end
        end

        WB_REQ: begin
          if (mem_store_completed) begin
            store_req_q <= 1'b0;
            state_q     <= WB_DRAIN;
          end
        end

        // The load may only start once the RAM has lowered its completion flag
        WB_DRAIN: begin
          if (!mem_store_completed) begin
            load_req_q   <= 1'b1;
            addr_mem_q   <= blk_addr(req_tag, req_idx);
            fill_first_q <= 1'b1;
            state_q      <= FILL_REQ;
          end
        end

        FILL_REQ: begin
          fill_first_q <= 1'b0;
          if (fill_take) begin
            valid_q[req_idx][way_q] <= 1'b1;
            dirty_q[req_idx][way_q] <= 1'b0;
            load_req_q              <= 1'b0;
            cpu_ready_q             <= 1'b1;
            if (type_q == READ) begin
              cpu_rdata_q <= half_of(data_f_mem, req_hi);
            end
            state_q <= RESPOND;
          end
        end

        RESPOND: begin
          cpu_ready_q <= 1'b0;
          cpu_err_q   <= 1'b0;
          if (!cpu_err_q && (type_q == WRITE)) begin
            dirty_q[req_idx][way_q] <= 1'b1;
          end
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata      = cpu_rdata_q;
  assign cpu_ready      = cpu_ready_q;
  assign cpu_err        = cpu_err_q;
  assign address_to_mem = addr_mem_q;
  assign data_to_mem    = data_mem_q;
  assign mem_store_req  = store_req_q;
  assign mem_load_req   = load_req_q;

endmodule
`default_nettype wire

// File: doc/cache_ctrl_fsm.md
Name: cache_ctrl_fsm

Overview:
Synthesizable, clocked controller for the 8-row, 4-way set-associative, write-back cache. It owns the tag, valid, dirty, LRU and data arrays. It accepts one CPU halfword request at a time and sequences hit, dirty-victim writeback and block refill over the existing RAM handshake (mem_load_req/mem_load_req_rdy, mem_store_req/mem_store_completed). It replaces the wait-based behavioural cache and sits between the pipeline memory stage and RAM.

Parameters:
CACHE_NUM_ROW, 8, rows (index = addr[4:2])
CACHE_NUM_SET, 4, ways per row
ADDR_W, 16, byte address width
WORD_W, 16, CPU data width
BLOCK_W, 32, cache block / memory word width (4 bytes)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  request valid; sampled only in IDLE
cpu_instr_type  in  INSTR_TYPE  READ or WRITE
cpu_addr  in  16  byte address; tag = [15:5], index = [4:2], half select = [1]
cpu_wdata  in  16  store data
cpu_rdata  out  16  load data; valid while cpu_ready = 1
cpu_ready  out  1  one-cycle completion pulse
cpu_err  out  1  pulses with cpu_ready on a misaligned address
address_to_mem  out  16  block-aligned address {tag, index, 2'b00}
data_to_mem  out  32  victim block
mem_store_req  out  1  store request
mem_store_completed  in  1  RAM has stored the block
mem_load_req  out  1  load request
mem_load_req_rdy  in  1  data_f_mem valid
data_f_mem  in  32  refill block

Behaviour:
- Reset (async, rst_n = 0): all outputs 0; state IDLE; all valid and dirty bits 0; LRU ages per row = {0,1,2,3} for ways 0..3. Tag and data arrays are not reset.
- Reset mid-operation: any outstanding mem_*_req drops immediately. The in-flight CPU request is lost and gets no cpu_ready.
- IDLE: when cpu_req = 1, latch addr, type and wdata, then go to LOOKUP. If addr[0] = 1, go to RESPOND with cpu_err = 1 and make no array change.
- LOOKUP (1 cycle): hit = valid && tag match in any way (at most one way matches).
  - Hit: go to RESPOND.
  - Miss: pick the victim. Use the lowest-index invalid way; otherwise use the way with age == 3. If the victim is valid and dirty, go to WB_REQ; else go to FILL_REQ.
- WB_REQ: drive mem_store_req = 1, data_to_mem = victim data, address_to_mem = {victim tag, index, 00}. Hold these until mem_store_completed = 1 is sampled, then drop the request and go to WB_DRAIN.
- WB_DRAIN: wait for mem_store_completed = 0, then go to FILL_REQ. A new memory request is never issued while completed is still high.
- FILL_REQ: drive mem_load_req = 1 and address_to_mem = {tag, index, 00}.
  - On the cycle mem_load_req_rdy = 1 is sampled: write data_f_mem into the victim way, set valid = 1, dirty = 0, store the tag, drop mem_load_req, and go to RESPOND.
  - If mem_load_req_rdy is already 1 on entry, it is ignored for one cycle; refill data is taken only from a rdy seen after the request was asserted.
- RESPOND (1 cycle): cpu_ready = 1.
  - READ: cpu_rdata = addr[1] ? block[31:16] : block[15:0].
  - WRITE: merge wdata into the selected half and set dirty = 1. Write-allocate: a write miss refills first, then merges.
  - LRU update: the accessed way gets age 0; ways whose age was below its old age increment; the others are unchanged.
  - Next state is IDLE. cpu_req held high starts a new request on the next cycle.
- Latency:
  - Hit: cpu_ready 2 cycles after acceptance.
  - Clean miss: 3 cycles plus memory load wait.
  - Dirty miss: adds the store handshake plus drain.
- cpu_rdata is held between responses.
- mem_store_req and mem_load_req are never high together.

Decomposition:
- cache_pkg:
  - INSTR_TYPE {READ, WRITE}
  - ctrl_state_t {IDLE, LOOKUP, WB_REQ, WB_DRAIN, FILL_REQ, RESPOND}
  - TAG_W = 11, IDX_W = 3, OFF_W = 2
  - tag_of / idx_of functions
- One sub-module, cache_lru: per-row 4x2-bit age vector, update input (way, enable), victim output (age == 3 way).

Test Plan:
- Reset, then idle -> all outputs 0; a read of 0x0004 misses (all valid bits cleared).
- RAM mem[i] = i; READ 0x0028 -> mem_load_req with address_to_mem 0x0028, cpu_rdata 0x0028. Second READ 0x002A -> hit, cpu_ready 2 cycles after acceptance, cpu_rdata 0x0000, no mem_*_req activity.
- WRITE 0x0008 = 0xDEAD (miss, refill mem[8] = 0x00000008), then READ 0x0008 -> 0xDEAD and READ 0x000A -> 0x0000; no mem_store_req.
- WRITE 0x0100 to 0x0004, then writes to 0x0024, 0x0044, 0x0064 (fills index 1), then WRITE 0x0084 -> store of data_to_mem 0x00000100 at address 0x0004 precedes the load of 0x0084. No new memory request is issued while mem_store_completed = 1.
- READ 0x0003 -> cpu_ready and cpu_err high for 1 cycle, no memory requests, arrays unchanged.
- Assert rst_n = 0 during FILL_REQ -> mem_load_req drops asynchronously, no cpu_ready; a READ of the same address after reset misses again.
